// File: rtl/uart_sv_pkg.sv
// Shared types and constants for the uart_sv block: FSM encodings, Rx_Error
// bit positions and the fixed self-test pattern set.
package uart_sv_pkg;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_PARITY,
      TX_STOP
   } tx_state_t;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_PARITY,
      RX_STOP,
      RX_WAIT_HIGH
   } rx_state_t;

   typedef enum logic [1:0] {
      B_IDLE,
      B_PEND,
      B_RUN
   } bist_state_t;

   localparam int unsigned ERR_PARITY = 0;
   localparam int unsigned ERR_FRAME  = 1;
   localparam int unsigned ERR_BREAK  = 2;

   localparam int unsigned BIST_COUNT = 4;
   // Element 0 is sent first; callers truncate to DATA_BITS.
   localparam logic [BIST_COUNT-1:0][8:0] BIST_PATTERNS = {9'h0FF, 9'h000, 9'h0AA, 9'h055};

endpackage

// File: rtl/uart_sv_fifo.sv
// Synchronous transmit FIFO with show-ahead read data; pointers wrap modulo DEPTH.
module uart_sv_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);
   localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNTW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNTW-1:0]  count_q, count_d;
   logic             do_push, do_pop;

   function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full    = (count_q == CNTW'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = do_push ? bump(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = do_pop ? bump(rd_ptr_q) : rd_ptr_q;
      count_d  = count_q + CNTW'(do_push) - CNTW'(do_pop);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/uart_sv.sv
// Full-duplex UART with TX FIFO, CTS/RTS flow control and an internal
// loopback self-test that replays a fixed pattern set through TX and RX.
module uart_sv
   import uart_sv_pkg::*;
#(
   parameter int unsigned SYSCLK_RATE = 100000000,
   parameter int unsigned BAUD_RATE   = 9600,
   parameter int unsigned DATA_BITS   = 8,
   parameter int unsigned PARITY_BIT  = 1,
   parameter int unsigned STOP_BITS   = 2,
   parameter int unsigned FIFO_SIZE   = 8
) (
   input  logic                 SysClk,
   input  logic                 Rst,
   input  logic                 Rx,
   input  logic                 CTS,
   input  logic [DATA_BITS-1:0] Tx_Data,
   input  logic                 Transmit_Start,
   input  logic                 BIST_Start,
   output logic [DATA_BITS-1:0] Rx_Data,
   output logic                 Data_Rdy,
   output logic [2:0]           Rx_Error,
   output logic                 BIST_Busy,
   output logic                 BIST_Error,
   output logic                 Tx,
   output logic                 RTS
);
   localparam int unsigned DIV = SYSCLK_RATE / BAUD_RATE;
   localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned BW  = $clog2(DATA_BITS);
   localparam logic [CW-1:0] DIV_M1    = CW'(DIV - 1);
   localparam logic [CW-1:0] MID       = CW'(DIV / 2);
   localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
   localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

   tx_state_t   tx_state_q, tx_state_d;
   rx_state_t   rx_state_q, rx_state_d;
   bist_state_t bist_state_q, bist_state_d;

   logic                 ts_prev_q, bs_prev_q, rst_done_q;
   logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [DATA_BITS-1:0] fifo_dout, tx_word;
   logic [CW-1:0]        tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
   logic [BW-1:0]        tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
   logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
   logic                 tx_stop_q, tx_stop_d, tx_par_q, tx_par_d;
   logic                 rx_par_q, rx_par_d, rx_stop_q, rx_stop_d;
   logic                 rx_s1_q, rx_s2_q, rx_in, stop_now;
   logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
   logic [2:0]           rx_err_q, rx_err_d;
   logic                 rdy_q, rdy_d;
   logic [2:0]           bist_sent_q, bist_sent_d;
   logic [1:0]           bist_rcvd_q, bist_rcvd_d;
   logic                 bist_err_q, bist_err_d;
   logic                 tx_ser, tx_end, tx_ready, rx_mid, rx_end;
   logic                 bist_go, loopback, load_bist, load_fifo;

   assign fifo_push = Transmit_Start && !ts_prev_q && !fifo_full;

   uart_sv_fifo #(
      .DEPTH(FIFO_SIZE),
      .WIDTH(DATA_BITS)
   ) u_fifo (
      .clk  (SysClk),
      .rst_n(Rst),
      .push (fifo_push),
      .pop  (fifo_pop),
      .din  (Tx_Data),
      .dout (fifo_dout),
      .full (fifo_full),
      .empty(fifo_empty)
   );

   assign bist_go   = BIST_Start && !bs_prev_q && (bist_state_q == B_IDLE);
   assign loopback  = (bist_state_q == B_RUN);
   assign load_bist = loopback && (bist_sent_q < 3'(BIST_COUNT));
   // A self-test request claims TX in the same cycle, so no FIFO word slips in.
   assign load_fifo = (bist_state_q == B_IDLE) && !bist_go && !fifo_empty && CTS;
   assign tx_word   = load_bist ? BIST_PATTERNS[bist_sent_q[1:0]][DATA_BITS-1:0] : fifo_dout;
   assign tx_end    = (tx_cnt_q == DIV_M1);
   assign tx_ready  = (tx_state_q == TX_IDLE) ||
                      ((tx_state_q == TX_STOP) && tx_end && (tx_stop_q == LAST_STOP));

   always_comb begin
      tx_state_d  = tx_state_q;
      tx_cnt_d    = tx_cnt_q;
      tx_bit_d    = tx_bit_q;
      tx_stop_d   = tx_stop_q;
      tx_sh_d     = tx_sh_q;
      tx_par_d    = tx_par_q;
      fifo_pop    = 1'b0;
      bist_sent_d = loopback ? bist_sent_q : '0;
      if (tx_ready) begin
         tx_state_d = TX_IDLE;
         tx_cnt_d   = '0;
         if (load_bist || load_fifo) begin
            tx_state_d = TX_START;
            tx_sh_d    = tx_word;
            tx_par_d   = ^tx_word;
            fifo_pop   = load_fifo;
            if (load_bist) bist_sent_d = bist_sent_q + 3'd1;
         end
      end else begin
         tx_cnt_d = tx_end ? '0 : tx_cnt_q + 1'b1;
         if (tx_end) begin
            case (tx_state_q)
               TX_START: begin
                  tx_state_d = TX_DATA;
                  tx_bit_d   = '0;
               end
               TX_DATA: begin
                  if (tx_bit_q == LAST_BIT) begin
                     tx_state_d = (PARITY_BIT != 0) ? TX_PARITY : TX_STOP;
                     tx_stop_d  = 1'b0;
                  end else begin
                     tx_bit_d = tx_bit_q + 1'b1;
                     tx_sh_d  = tx_sh_q >> 1;
                  end
               end
               TX_PARITY: begin
                  tx_state_d = TX_STOP;
                  tx_stop_d  = 1'b0;
               end
               TX_STOP: tx_stop_d = 1'b1;
               default: tx_state_d = TX_IDLE;
            endcase
         end
      end
   end

   always_comb begin
      case (tx_state_q)
         TX_START:  tx_ser = 1'b0;
         TX_DATA:   tx_ser = tx_sh_q[0];
         TX_PARITY: tx_ser = tx_par_q;
         default:   tx_ser = 1'b1;
      endcase
   end

   assign rx_in    = loopback ? tx_ser : rx_s2_q;
   assign rx_mid   = (rx_cnt_q == MID);
   assign rx_end   = (rx_cnt_q == DIV_M1);
   assign stop_now = rx_mid ? rx_in : rx_stop_q;

   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_bit_d   = rx_bit_q;
      rx_sh_d    = rx_sh_q;
      rx_par_d   = rx_par_q;
      rx_stop_d  = rx_stop_q;
      rx_data_d  = rx_data_q;
      rx_err_d   = rx_err_q;
      rdy_d      = 1'b0;
      if (rx_state_q inside {RX_START, RX_DATA, RX_PARITY, RX_STOP})
         rx_cnt_d = rx_end ? '0 : rx_cnt_q + 1'b1;
      case (rx_state_q)
         RX_IDLE: begin
            // The detecting cycle is count 0 of the start bit; with DIV=1 it is also its sample.
            if (!rx_in) begin
               rx_state_d = (DIV == 1) ? RX_DATA : RX_START;
               rx_cnt_d   = (DIV == 1) ? '0 : CW'(1);
               rx_bit_d   = '0;
            end
         end
         RX_START: begin
            if (rx_mid && rx_in) begin
               rx_state_d = RX_IDLE;
               rx_cnt_d   = '0;
            end else if (rx_end) begin
               rx_state_d = RX_DATA;
               rx_bit_d   = '0;
            end
         end
         RX_DATA: begin
            if (rx_mid) rx_sh_d = {rx_in, rx_sh_q[DATA_BITS-1:1]};
            if (rx_end) begin
               if (rx_bit_q == LAST_BIT) rx_state_d = (PARITY_BIT != 0) ? RX_PARITY : RX_STOP;
               else rx_bit_d = rx_bit_q + 1'b1;
            end
         end
         RX_PARITY: begin
            if (rx_mid) rx_par_d = rx_in;
            if (rx_end) rx_state_d = RX_STOP;
         end
         RX_STOP: begin
            if (rx_mid) rx_stop_d = rx_in;
            if (rx_end) begin
               rdy_d                = 1'b1;
               rx_data_d            = rx_sh_q;
               rx_err_d[ERR_PARITY] = (PARITY_BIT != 0) && ((^rx_sh_q) != rx_par_q);
               rx_err_d[ERR_FRAME]  = !stop_now;
               rx_err_d[ERR_BREAK]  = (rx_sh_q == '0) && ((PARITY_BIT == 0) || !rx_par_q) && !stop_now;
               rx_state_d           = stop_now ? RX_IDLE : RX_WAIT_HIGH;
            end
         end
         RX_WAIT_HIGH: if (rx_in) rx_state_d = RX_IDLE;
         default: rx_state_d = RX_IDLE;
      endcase
   end

   always_comb begin
      bist_state_d = bist_state_q;
      bist_rcvd_d  = bist_rcvd_q;
      bist_err_d   = bist_err_q;
      case (bist_state_q)
         B_IDLE: begin
            if (bist_go) begin
               bist_err_d   = 1'b0;
               bist_rcvd_d  = '0;
               bist_state_d = (tx_state_q == TX_IDLE) ? B_RUN : B_PEND;
            end
         end
         B_PEND: if (tx_state_q == TX_IDLE) bist_state_d = B_RUN;
         B_RUN: begin
            if (rdy_q) begin
               if ((rx_data_q != BIST_PATTERNS[bist_rcvd_q][DATA_BITS-1:0]) || (rx_err_q != '0))
                  bist_err_d = 1'b1;
               if (bist_rcvd_q == 2'(BIST_COUNT - 1)) bist_state_d = B_IDLE;
               else bist_rcvd_d = bist_rcvd_q + 2'd1;
            end
         end
         default: bist_state_d = B_IDLE;
      endcase
   end

   always_ff @(posedge SysClk) begin
      if (!Rst) begin
         tx_state_q   <= TX_IDLE;
         rx_state_q   <= RX_IDLE;
         bist_state_q <= B_IDLE;
         ts_prev_q    <= 1'b0;
         bs_prev_q    <= 1'b0;
         rst_done_q   <= 1'b0;
         tx_cnt_q     <= '0;
         tx_bit_q     <= '0;
         tx_stop_q    <= 1'b0;
         tx_sh_q      <= '0;
         tx_par_q     <= 1'b0;
         rx_cnt_q     <= '0;
         rx_bit_q     <= '0;
         rx_sh_q      <= '0;
         rx_par_q     <= 1'b0;
         rx_stop_q    <= 1'b1;
         rx_s1_q      <= 1'b1;
         rx_s2_q      <= 1'b1;
         rx_data_q    <= '0;
         rx_err_q     <= '0;
         rdy_q        <= 1'b0;
         bist_sent_q  <= '0;
         bist_rcvd_q  <= '0;
         bist_err_q   <= 1'b0;
      end else begin
         tx_state_q   <= tx_state_d;
         rx_state_q   <= rx_state_d;
         bist_state_q <= bist_state_d;
         ts_prev_q    <= Transmit_Start;
         bs_prev_q    <= BIST_Start;
         rst_done_q   <= 1'b1;
         tx_cnt_q     <= tx_cnt_d;
         tx_bit_q     <= tx_bit_d;
         tx_stop_q    <= tx_stop_d;
         tx_sh_q      <= tx_sh_d;
         tx_par_q     <= tx_par_d;
         rx_cnt_q     <= rx_cnt_d;
         rx_bit_q     <= rx_bit_d;
         rx_sh_q      <= rx_sh_d;
         rx_par_q     <= rx_par_d;
         rx_stop_q    <= rx_stop_d;
         rx_s1_q      <= Rx;
         rx_s2_q      <= rx_s1_q;
         rx_data_q    <= rx_data_d;
         rx_err_q     <= rx_err_d;
         rdy_q        <= rdy_d;
         bist_sent_q  <= bist_sent_d;
         bist_rcvd_q  <= bist_rcvd_d;
         bist_err_q   <= bist_err_d;
      end
   end

   assign Rx_Data    = rx_data_q;
   assign Rx_Error   = rx_err_q;
   assign Data_Rdy   = rdy_q;
   assign BIST_Busy  = (bist_state_q != B_IDLE);
   assign BIST_Error = bist_err_q;
   assign Tx         = loopback ? 1'b1 : tx_ser;
   assign RTS        = rst_done_q && !BIST_Busy;

endmodule

// File: tb/tb_uart_sv.sv
// Directed bench for uart_sv at DIV=1: one bit per clock, inputs driven and
// outputs sampled on the falling edge.
module tb_uart_sv;

   logic       clk = 1'b0;
   logic       Rst, Rx, CTS, Transmit_Start, BIST_Start;
   logic [7:0] Tx_Data;
   logic [7:0] Rx_Data;
   logic       Data_Rdy, BIST_Busy, BIST_Error, Tx, RTS;
   logic [2:0] Rx_Error;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;
   int unsigned n_fail   = 0;

   always #5 clk = ~clk;

   uart_sv #(
      .SYSCLK_RATE(9600),
      .BAUD_RATE  (9600),
      .DATA_BITS  (8),
      .PARITY_BIT (1),
      .STOP_BITS  (2),
      .FIFO_SIZE  (8)
   ) dut (
      .SysClk        (clk),
      .Rst           (Rst),
      .Rx            (Rx),
      .CTS           (CTS),
      .Tx_Data       (Tx_Data),
      .Transmit_Start(Transmit_Start),
      .BIST_Start    (BIST_Start),
      .Rx_Data       (Rx_Data),
      .Data_Rdy      (Data_Rdy),
      .Rx_Error      (Rx_Error),
      .BIST_Busy     (BIST_Busy),
      .BIST_Error    (BIST_Error),
      .Tx            (Tx),
      .RTS           (RTS)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [7:0] d);
      Tx_Data = d;
      Transmit_Start = 1'b1;
      @(negedge clk);
      Transmit_Start = 1'b0;
      @(negedge clk);
   endtask

   // Drives 12 bit times LSB first, then idle; reports strobe count and the last strobed values.
   task automatic drive_rx(input logic [11:0] bits, output int unsigned pulses,
                           output logic [7:0] data, output logic [2:0] err);
      pulses = 0;
      data   = '0;
      err    = '0;
      for (int unsigned i = 0; i < 20; i++) begin
         Rx = (i < 12) ? bits[i] : 1'b1;
         @(negedge clk);
         if (Data_Rdy === 1'b1) begin
            pulses++;
            data = Rx_Data;
            err  = Rx_Error;
         end
      end
   endtask

   task automatic get_tx_frame(input int unsigned lim, output logic [7:0] b, output logic p,
                               output logic [1:0] st, output logic seen);
      seen = 1'b0;
      b    = '0;
      p    = 1'b0;
      st   = '0;
      for (int unsigned i = 0; i < lim && !seen; i++) begin
         @(negedge clk);
         if (Tx === 1'b0) seen = 1'b1;
      end
      if (seen) begin
         for (int unsigned k = 0; k < 8; k++) begin
            @(negedge clk);
            b[k] = Tx;
         end
         @(negedge clk);
         p = Tx;
         @(negedge clk);
         st[0] = Tx;
         @(negedge clk);
         st[1] = Tx;
      end
   endtask

   initial begin
      logic [11:0] aa_seq;
      logic [7:0]  par_1_8;
      logic [7:0]  b, rd;
      logic [2:0]  re;
      logic [1:0]  st;
      logic        p, seen;
      int unsigned pulses, zeros, nrdy, txbad, strobe_at, drop_at, errs_or;
      logic [7:0]  got [4];
      logic        done;

      aa_seq  = 12'b1101_0101_0100;
      par_1_8 = 8'b1100_1011;

      Rst = 1'b0; Rx = 1'b1; CTS = 1'b1; Transmit_Start = 1'b0; BIST_Start = 1'b0; Tx_Data = '0;
      repeat (3) @(negedge clk);
      check("rst_tx", 32'(Tx), 1);
      check("rst_rts", 32'(RTS), 0);
      check("rst_rx_data", 32'(Rx_Data), 0);
      check("rst_rdy", 32'(Data_Rdy), 0);
      check("rst_rx_err", 32'(Rx_Error), 0);
      check("rst_bist_busy", 32'(BIST_Busy), 0);
      check("rst_bist_err", 32'(BIST_Error), 0);
      Rst = 1'b1;
      @(negedge clk);
      check("rts_after_rst", 32'(RTS), 1);

      // Transmit 0xAA: start, LSB-first data, even parity 0, two stops.
      Tx_Data = 8'hAA;
      Transmit_Start = 1'b1;
      @(negedge clk);
      Transmit_Start = 1'b0;
      seen = 1'b0;
      for (int unsigned i = 0; i < 4 && !seen; i++) begin
         if (Tx === 1'b0) seen = 1'b1;
         else @(negedge clk);
      end
      check("aa_start_seen", 32'(seen), 1);
      for (int unsigned i = 0; i < 12; i++) begin
         check($sformatf("aa_bit%0d", i), 32'(Tx), 32'(aa_seq[i]));
         @(negedge clk);
      end
      check("aa_idle", 32'(Tx), 1);

      drive_rx({1'b1, 1'b1, 1'b0, 8'h3C, 1'b0}, pulses, rd, re);
      check("rx_ok_pulses", pulses, 1);
      check("rx_ok_data", 32'(rd), 32'h3C);
      check("rx_ok_err", 32'(re), 0);

      drive_rx({1'b1, 1'b1, 1'b1, 8'h3C, 1'b0}, pulses, rd, re);
      check("rx_par_pulses", pulses, 1);
      check("rx_par_data", 32'(rd), 32'h3C);
      check("rx_par_err", 32'(re), 32'b001);

      drive_rx({1'b1, 1'b0, 1'b0, 8'h3C, 1'b0}, pulses, rd, re);
      check("rx_frm_pulses", pulses, 1);
      check("rx_frm_err", 32'(re), 32'b010);
      check("rx_hold_data", 32'(Rx_Data), 32'h3C);

      drive_rx(12'h000, pulses, rd, re);
      check("rx_brk_pulses", pulses, 1);
      check("rx_brk_data", 32'(rd), 0);
      check("rx_brk_err", 32'(re), 32'b110);

      // CTS low holds a queued word; raising it releases the frame.
      CTS = 1'b0;
      push(8'h11);
      zeros = 0;
      for (int unsigned i = 0; i < 10; i++) begin
         @(negedge clk);
         if (Tx !== 1'b1) zeros++;
      end
      check("cts_hold", zeros, 0);
      CTS = 1'b1;
      get_tx_frame(2, b, p, st, seen);
      check("cts_start_seen", 32'(seen), 1);
      check("cts_data", 32'(b), 32'h11);
      check("cts_par", 32'(p), 0);
      check("cts_stop", 32'(st), 32'b11);

      // Nine pushes into an 8-deep FIFO; the ninth is dropped.
      CTS = 1'b0;
      for (int unsigned i = 1; i <= 9; i++) push(8'(i));
      CTS = 1'b1;
      for (int unsigned i = 0; i < 8; i++) begin
         get_tx_frame(2, b, p, st, seen);
         check($sformatf("fifo_seen%0d", i), 32'(seen), 1);
         check($sformatf("fifo_data%0d", i), 32'(b), 32'(i + 1));
         check($sformatf("fifo_par%0d", i), 32'(p), 32'(par_1_8[i]));
         check($sformatf("fifo_stop%0d", i), 32'(st), 32'b11);
      end
      zeros = 0;
      for (int unsigned i = 0; i < 30; i++) begin
         @(negedge clk);
         if (Tx !== 1'b1) zeros++;
      end
      check("fifo_drop_9", zeros, 0);

      // Self-test through internal loopback.
      BIST_Start = 1'b1;
      @(negedge clk);
      BIST_Start = 1'b0;
      check("bist_busy_set", 32'(BIST_Busy), 1);
      check("bist_rts_low", 32'(RTS), 0);
      nrdy = 0; txbad = 0; strobe_at = 0; drop_at = 0; errs_or = 0; done = 1'b0;
      for (int unsigned c = 1; c < 200 && !done; c++) begin
         @(negedge clk);
         if (BIST_Busy !== 1'b1) begin
            done = 1'b1;
            drop_at = c;
         end else if (Tx !== 1'b1) txbad++;
         if (Data_Rdy === 1'b1) begin
            if (nrdy < 4) got[nrdy] = Rx_Data;
            errs_or = errs_or | 32'(Rx_Error);
            nrdy++;
            strobe_at = c;
         end
      end
      check("bist_done", 32'(done), 1);
      check("bist_strobes", nrdy, 4);
      check("bist_rx0", 32'(got[0]), 32'h55);
      check("bist_rx1", 32'(got[1]), 32'hAA);
      check("bist_rx2", 32'(got[2]), 32'h00);
      check("bist_rx3", 32'(got[3]), 32'hFF);
      check("bist_rx_err", errs_or, 0);
      check("bist_tx_pin", txbad, 0);
      check("bist_drop_timing", drop_at, strobe_at + 1);
      check("bist_error", 32'(BIST_Error), 0);

      // Reset in the middle of a self-test run.
      BIST_Start = 1'b1;
      @(negedge clk);
      BIST_Start = 1'b0;
      repeat (20) @(negedge clk);
      check("mid_bist_busy", 32'(BIST_Busy), 1);
      Rst = 1'b0;
      @(negedge clk);
      check("mrst_tx", 32'(Tx), 1);
      check("mrst_rts", 32'(RTS), 0);
      check("mrst_rx_data", 32'(Rx_Data), 0);
      check("mrst_rdy", 32'(Data_Rdy), 0);
      check("mrst_rx_err", 32'(Rx_Error), 0);
      check("mrst_bist_busy", 32'(BIST_Busy), 0);
      check("mrst_bist_err", 32'(BIST_Error), 0);
      Rst = 1'b1;
      @(negedge clk);
      check("mrst_rts_release", 32'(RTS), 1);
      check("mrst_tx_idle", 32'(Tx), 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
